// File: rtl/dmem_responder.sv
// Data-memory responder for the Y86-64 memory stage: one load/store at a time,
// fixed service latency, byte-addressed little-endian storage with range check.
module dmem_responder #(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);
    localparam int unsigned AW        = $clog2(MEM_BYTES);
    localparam int unsigned NUM_LANES = 8;
    localparam logic [63:0] MAX_ADDR  = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    typedef struct packed {
        logic          write;
        logic          err;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
    } req_t;

    state_e                        state_q;
    logic [3:0]                    cnt_q;
    req_t                          req_q;
    req_t                          req_d;
    logic [NUM_LANES-1:0][7:0]     rd_lanes;
    logic                          commit;

    logic [7:0] mem [MEM_BYTES];

    // Range check on the raw 64-bit address so a request near 2^64 cannot wrap.
    always_comb begin
        req_d       = '0;
        req_d.write = req_write;
        req_d.err   = req_addr > MAX_ADDR;
        req_d.addr  = req_addr[AW-1:0];
        req_d.wdata = req_wdata;
    end

    assign req_ready = (state_q == IDLE);
    assign commit    = (state_q == BUSY) && (cnt_q == 4'd0) && !req_q.err && !reset;

    always_comb begin
        rd_lanes = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rd_lanes[l] = mem[req_q.addr + AW'(l)];
        end
    end

    // Storage has no reset; a store reaches it only in its final BUSY cycle.
    always_ff @(posedge clock) begin
        if (commit && req_q.write) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                mem[req_q.addr + AW'(l)] <= req_q.wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q   <= req_d;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_error <= req_q.err;
                        resp_rdata <= (req_q.err || req_q.write) ? '0 : rd_lanes;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 3, 1) driven
// by random and directed traffic, checked against a byte-array memory model.
module tb_dmem_responder;
    localparam int NI   = 3;
    localparam int MEMB = 2048;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clock;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [63:0] req_addr   [NI];
    logic [63:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [63:0] resp_rdata [NI];
    logic        resp_error [NI];

    exp_t        sbq [NI][$];
    byte unsigned mdl [NI][MEMB];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          in_resp  [NI];
    bit          hs_pend  [NI];
    bit          rr_always[NI];
    int          hold_lo  [NI];
    logic [63:0] held_d   [NI];
    logic        held_e   [NI];
    logic [63:0] last_data[NI];
    logic        last_err [NI];

    dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(2)) u_dut0 (
        .clock(clock), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));
    dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(3)) u_dut1 (
        .clock(clock), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));
    dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(1)) u_dut2 (
        .clock(clock), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(int i, bit wr, logic [63:0] a, logic [63:0] wd, bit track,
                          output int acc);
        exp_t e;
        int   waited = 0;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        while (!req_ready[i] && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready[i]) begin
            chk("accept_timeout", 64'(req_ready[i]), 64'd1);
            req_valid[i] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (track) begin
            e.err  = (a > 64'(MEMB - 8));
            e.data = 64'd0;
            e.acc  = acc;
            if (!e.err) begin
                for (int k = 0; k < 8; k++) begin
                    if (wr) mdl[i][int'(a) + k] = wd[8*k +: 8];
                    else    e.data = e.data | (64'(mdl[i][int'(a) + k]) << (8*k));
                end
            end
            sbq[i].push_back(e);
        end
        @(negedge clock);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(int i);
        int n = 0;
        while ((sbq[i].size() != 0 || resp_valid[i]) && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        if (n >= 200) chk("drain_timeout", 64'(n), 64'd0);
    endtask

    task automatic init_mem(int i);
        int a;
        for (int j = 0; j < MEMB / 8; j++) begin
            do_req(i, 1'b1, 64'(8 * j), {$urandom, $urandom}, 1'b1, a);
        end
        drain(i);
    endtask

    task automatic rand_traffic(int i, int n);
        int          a;
        int unsigned sel;
        logic [63:0] ad;
        for (int t = 0; t < n; t++) begin
            sel = $urandom_range(0, 99);
            if (sel < 80)      ad = 64'($urandom_range(0, MEMB - 1));
            else if (sel < 95) ad = 64'($urandom_range(MEMB - 16, MEMB - 1));
            else               ad = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            do_req(i, 1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, 1'b1, a);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        drain(i);
    endtask

    // Response monitor: pops the scoreboard on each new response and checks
    // latency, hold-stability under backpressure and the drop after handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) begin
                if (hs_pend[i]) begin
                    chk("resp_drop", 64'(resp_valid[i]), 64'd0);
                    hs_pend[i] = 1'b0;
                    in_resp[i] = 1'b0;
                end
                if (resp_valid[i]) begin
                    chk("req_ready_in_resp", 64'(req_ready[i]), 64'd0);
                    if (!in_resp[i]) begin
                        if (sbq[i].size() == 0) begin
                            chk("unexpected_resp", 64'(resp_valid[i]), 64'd0);
                        end else begin
                            e = sbq[i].pop_front();
                            chk("resp_data", resp_rdata[i], e.data);
                            chk("resp_err", 64'(resp_error[i]), 64'(e.err));
                            chk("resp_latency", 64'(cyc - e.acc), 64'(lat_of(i)));
                        end
                        held_d[i]    = resp_rdata[i];
                        held_e[i]    = resp_error[i];
                        last_data[i] = resp_rdata[i];
                        last_err[i]  = resp_error[i];
                        in_resp[i]   = 1'b1;
                    end else begin
                        chk("hold_data", resp_rdata[i], held_d[i]);
                        chk("hold_err", 64'(resp_error[i]), 64'(held_e[i]));
                    end
                    if (hold_lo[i] > 0) begin
                        resp_ready[i] = 1'b0;
                        hold_lo[i]--;
                    end else begin
                        resp_ready[i] = rr_always[i] ? 1'b1 : ($urandom_range(0, 2) != 0);
                    end
                    if (resp_ready[i]) hs_pend[i] = 1'b1;
                end else begin
                    in_resp[i]    = 1'b0;
                    resp_ready[i] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        int a0, a1, a2;
        int accs[4];
        logic [63:0] pre200;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b0;
            in_resp[i] = 1'b0; hs_pend[i] = 1'b0; rr_always[i] = 1'b0; hold_lo[i] = 0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
            chk("rst_resp_rdata", resp_rdata[i], 64'd0);
            chk("rst_resp_error", 64'(resp_error[i]), 64'd0);
            rst[i] = 1'b0;
        end
        @(negedge clock);

        fork
            init_mem(0);
            init_mem(1);
            init_mem(2);
        join

        // Store/load round trip, aligned and unaligned.
        do_req(0, 1'b1, 64'h100, 64'h1122334455667788, 1'b1, a0);
        drain(0);
        chk("t2_store_err", 64'(last_err[0]), 64'd0);
        do_req(0, 1'b0, 64'h100, 64'd0, 1'b1, a0);
        drain(0);
        chk("t2_load100", last_data[0], 64'h1122334455667788);
        do_req(0, 1'b0, 64'h101, 64'd0, 1'b1, a0);
        drain(0);
        chk("t2_load101", last_data[0], {mdl[0][16'h108], 56'h11223344556677});

        // Backpressure with a second request held pending.
        rr_always[0] = 1'b1;
        hold_lo[0]   = 5;
        do_req(0, 1'b0, 64'h0F3, 64'd0, 1'b1, a0);
        do_req(0, 1'b0, 64'h0F8, 64'd0, 1'b1, a1);
        chk("t3_accept_gap", 64'(a1 - a0), 64'd9);
        drain(0);
        rr_always[0] = 1'b0;

        // Range boundaries.
        do_req(0, 1'b0, 64'h7F8, 64'd0, 1'b1, a0);
        drain(0);
        chk("t4_7f8_err", 64'(last_err[0]), 64'd0);
        do_req(0, 1'b0, 64'h7F9, 64'd0, 1'b1, a0);
        drain(0);
        chk("t4_7f9_err", 64'(last_err[0]), 64'd1);
        chk("t4_7f9_data", last_data[0], 64'd0);
        do_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, a0);
        drain(0);
        chk("t4_wrap_err", 64'(last_err[0]), 64'd1);
        do_req(0, 1'b0, 64'h7F8, 64'd0, 1'b1, a0);
        do_req(0, 1'b0, 64'h7F0, 64'd0, 1'b1, a0);
        do_req(0, 1'b0, 64'h000, 64'd0, 1'b1, a0);
        drain(0);

        // Reset while a store is in flight (LATENCY=3, cnt=2).
        pre200 = '0;
        for (int k = 0; k < 8; k++) pre200 = pre200 | (64'(mdl[1][16'h200 + k]) << (8*k));
        do_req(1, 1'b1, 64'h200, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, a2);
        rst[1] = 1'b1;
        @(negedge clock);
        rst[1] = 1'b0;
        chk("t5_ready_after_rst", 64'(req_ready[1]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            chk("t5_no_resp", 64'(resp_valid[1]), 64'd0);
            @(negedge clock);
        end
        do_req(1, 1'b0, 64'h200, 64'd0, 1'b1, a2);
        drain(1);
        chk("t5_load200", last_data[1], pre200);

        // LATENCY=1 back-to-back spacing.
        rr_always[2] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            do_req(2, 1'(t & 1), 64'(8 * t + 3), {$urandom, $urandom}, 1'b1, accs[t]);
        end
        for (int t = 1; t < 4; t++) chk("t6_spacing", 64'(accs[t] - accs[t-1]), 64'd3);
        drain(2);
        rr_always[2] = 1'b0;

        fork
            rand_traffic(0, 300);
            rand_traffic(2, 150);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
